// File: rtl/fifo_ram_ctrl.sv
// FIFO controller in front of a single-port RAM: arbitrates write/read requests,
// keeps pointers and occupancy, and returns read data two cycles after the grant.
module fifo_ram_ctrl #(
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  write,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  read,
   output logic                  write_ack,
   output logic                  read_ack,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata
);

   localparam logic [ADDR_WIDTH:0]   FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic                  prio_w;
   logic [1:0]            vld_pipe;
   logic                  wr_ok, rd_ok, grant_w, grant_r;

   assign full       = (count == FULL_CNT);
   assign empty      = (count == '0);
   assign data_valid = vld_pipe[1];

   // Reset gates requests so nothing is granted while it is held.
   assign wr_ok   = enable & write & ~full  & ~reset;
   assign rd_ok   = enable & read  & ~empty & ~reset;
   assign grant_w = wr_ok & (~rd_ok | prio_w);
   assign grant_r = rd_ok & (~wr_ok | ~prio_w);

   assign write_ack = grant_w;
   assign read_ack  = grant_r;

   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (grant_w) begin
         ram_en    = 1'b1;
         ram_we    = 1'b1;
         ram_addr  = wr_ptr;
         ram_wdata = data_in;
      end else if (grant_r) begin
         ram_en   = 1'b1;
         ram_addr = rd_ptr;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         prio_w   <= 1'b1;
         vld_pipe <= '0;
         data_out <= '0;
      end else begin
         if (grant_w) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            count  <= count + CNT_ONE;
         end else if (grant_r) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            count  <= count - CNT_ONE;
         end
         if (wr_ok && rd_ok)
            prio_w <= ~prio_w;
         // stage 0: RAM access in flight, stage 1: data_out just loaded
         vld_pipe <= {vld_pipe[0], grant_r};
         if (vld_pipe[0])
            data_out <= ram_rdata;
      end
   end

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Directed bench for fifo_ram_ctrl with a behavioural RAM; read data is checked
// by a scoreboard monitor that pops expected words on every data_valid pulse.
module tb_fifo_ram_ctrl;

   logic        clock = 1'b0;
   logic        reset, enable, write, read;
   logic [7:0]  data_in, data_out, ram_wdata, ram_rdata;
   logic        write_ack, read_ack, data_valid, full, empty, ram_en, ram_we;
   logic [14:0] count;
   logic [13:0] ram_addr;

   fifo_ram_ctrl #(.ADDR_WIDTH(14), .DATA_WIDTH(8)) dut (
      .clock(clock), .reset(reset), .enable(enable), .write(write),
      .data_in(data_in), .read(read), .write_ack(write_ack), .read_ack(read_ack),
      .data_out(data_out), .data_valid(data_valid), .full(full), .empty(empty),
      .count(count), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clock = ~clock;

   logic [7:0] mem [0:16383];
   always @(posedge clock)
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata     <= mem[ram_addr];
      end

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int vectors = 0, errs = 0;
   logic [7:0] mq[$];   // FIFO contents model
   logic [7:0] ed[$];   // expected read words
   int         edue[$]; // cycle in which each word must be presented
   logic       wa, ra, ea, we;
   logic [13:0] ad;
   logic [7:0]  wd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step(input logic w, input logic r, input logic en, input logic rst,
                       input logic [7:0] d);
      write = w; read = r; enable = en; reset = rst; data_in = d;
      if (rst) begin
         // anything due after this cycle is killed by the reset edge
         while (edue.size() > 0 && edue[edue.size()-1] > cyc) begin
            void'(ed.pop_back());
            void'(edue.pop_back());
         end
         mq.delete();
      end
      @(negedge clock);
      wa = write_ack; ra = read_ack; ea = ram_en; we = ram_we; ad = ram_addr; wd = ram_wdata;
      if (wa) mq.push_back(d);
      if (ra) begin
         if (mq.size() == 0) chk("model_underflow", 1, 0);
         else begin
            ed.push_back(mq.pop_front());
            edue.push_back(cyc + 2);
         end
      end
      @(posedge clock); #1;
   endtask

   initial forever begin
      @(negedge clock);
      if (data_valid === 1'b1) begin
         if (ed.size() == 0) begin
            vectors++; errs++;
            $display("FAIL unexpected_data_valid: data_out %0h at cycle %0d, required no pulse",
                     data_out, cyc);
         end else begin
            chk("read_data", data_out, ed.pop_front());
            chk("read_latency", cyc, edue.pop_front());
         end
      end
   end

   initial begin
      write = 0; read = 0; enable = 0; reset = 1; data_in = 0;
      // reset state, requests blocked during reset
      step(1, 1, 1, 1, 8'h33);
      chk("rst_write_ack", wa, 0); chk("rst_read_ack", ra, 0); chk("rst_ram_en", ea, 0);
      step(0, 0, 0, 1, 0);
      chk("rst_count", count, 0); chk("rst_empty", empty, 1); chk("rst_full", full, 0);
      chk("rst_data_out", data_out, 0); chk("rst_data_valid", data_valid, 0);

      // ten writes then ten reads
      for (int i = 0; i < 10; i++) begin
         step(1, 0, 1, 0, 8'(i + 1));
         chk("w10_ack", wa, 1); chk("w10_addr", ad, i); chk("w10_we", we, 1);
         chk("w10_wdata", wd, i + 1);
      end
      chk("w10_count", count, 10); chk("w10_empty", empty, 0);
      for (int i = 0; i < 10; i++) begin
         step(0, 1, 1, 0, 0);
         chk("r10_ack", ra, 1); chk("r10_addr", ad, i); chk("r10_we", we, 0);
      end
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
      chk("r10_count", count, 0); chk("r10_empty", empty, 1); chk("idle_ram_en", ea, 0);

      // conflict arbitration starting from count 5
      for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 8'(8'h11 + i));
      chk("pre_conf_count", count, 5);
      for (int i = 0; i < 6; i++) begin
         step(1, 1, 1, 0, 8'(8'h21 + i));
         chk("conf_wack", wa, (i % 2 == 0) ? 1 : 0);
         chk("conf_rack", ra, (i % 2 == 1) ? 1 : 0);
         chk("conf_count", count, (i % 2 == 0) ? 6 : 5);
      end
      for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
      chk("conf_drain_count", count, 0);

      // enable low blocks grants but lets an in-flight read finish
      step(1, 0, 1, 0, 8'h77);
      step(0, 1, 1, 0, 0);
      chk("en_rack", ra, 1);
      step(1, 1, 0, 0, 8'h99);
      chk("dis_wack", wa, 0); chk("dis_rack", ra, 0); chk("dis_ram_en", ea, 0);
      step(1, 1, 0, 0, 8'h99);
      step(0, 0, 0, 0, 0);
      chk("dis_count", count, 0); chk("dis_drained", ed.size(), 0);

      // read while empty is ignored
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 1, 0, 0);
         chk("empty_rack", ra, 0); chk("empty_ram_en", ea, 0);
      end
      chk("empty_count", count, 0);

      // reset one cycle after a read grant discards it
      step(1, 0, 1, 0, 8'h5A);
      step(0, 1, 1, 0, 0);
      chk("flight_rack", ra, 1);
      step(0, 0, 1, 1, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("flight_count", count, 0); chk("flight_empty", empty, 1);

      // fill to full, overflow attempt, wrap of the write pointer
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 16384; i++) begin
         step(1, 0, 1, 0, 8'(i));
         if (wa !== 1'b1 || ad !== 14'(i)) chk("fill_ack_addr", {wa, 14'(ad)}, {1'b1, 14'(i)});
      end
      vectors++;
      chk("fill_full", full, 1); chk("fill_count", count, 16384); chk("fill_empty", empty, 0);
      step(1, 0, 1, 0, 8'hEE);
      chk("ovf_wack", wa, 0); chk("ovf_ram_en", ea, 0); chk("ovf_count", count, 16384);
      step(0, 1, 1, 0, 0);
      chk("full_rack", ra, 1); chk("full_raddr", ad, 0); chk("after_read_full", full, 0);
      step(1, 0, 1, 0, 8'hC3);
      chk("wrap_wack", wa, 1); chk("wrap_addr", ad, 0); chk("wrap_full", full, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
      chk("final_pending", ed.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/fifo_ram_ctrl.md
FIFO_RAM_CTRL -- requirements
Module: fifo_ram_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 14, RAM address width; depth DEPTH = 2^ADDR_WIDTH = 16384.
REQ-002 Parameter DATA_WIDTH, default 8, data word width.
REQ-003 clock  in  1  single clock for the whole block; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  global grant enable; 0 blocks new grants.
REQ-006 write  in  1  write request; held by the requester until write_ack.
REQ-007 data_in  in  DATA_WIDTH  write data, sampled in the write_ack cycle.
REQ-008 read  in  1  read request; held until read_ack.
REQ-009 write_ack  out  1  write accepted this cycle (combinational).
REQ-010 read_ack  out  1  read accepted this cycle (combinational).
REQ-011 data_out  out  DATA_WIDTH  registered read data; held between reads.
REQ-012 data_valid  out  1  one-cycle pulse marking new data_out.
REQ-013 full  out  1  count == DEPTH.
REQ-014 empty  out  1  count == 0.
REQ-015 count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
REQ-016 ram_en, ram_we  out  1 each  single-port RAM enable and write strobe.
REQ-017 ram_addr  out  ADDR_WIDTH  RAM address.
REQ-018 ram_wdata  out  DATA_WIDTH  RAM write data.
REQ-019 ram_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after a read access.

Function
REQ-020 Per cycle: wr_ok = enable & write & ~full; rd_ok = enable & read & ~empty; at most one grant per cycle (single-port RAM).
REQ-021 Only one of wr_ok/rd_ok true: that side is granted.
REQ-022 Both true (conflict): grant the side given by priority flag prio; prio toggles after every conflict grant; prio unchanged on non-conflict cycles; prio = write after reset.
REQ-023 Write grant: ram_en=1, ram_we=1, ram_addr=wr_ptr, ram_wdata=data_in, write_ack=1 in the same cycle; wr_ptr increments at the edge.
REQ-024 Read grant: ram_en=1, ram_we=0, ram_addr=rd_ptr, read_ack=1 in the same cycle; rd_ptr increments at the edge.
REQ-025 Read latency: grant in cycle N -> ram_rdata valid in N+1 -> data_out updated and data_valid=1 in N+2 only; back-to-back reads give back-to-back data_valid.
REQ-026 No grant: ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, both acks 0.
REQ-027 Pointers wrap DEPTH-1 -> 0 modulo 2^ADDR_WIDTH.
REQ-028 count +1 on write grant, -1 on read grant, else unchanged; never exceeds DEPTH, never below 0.
REQ-029 Write when full and read when empty are ignored: ack 0, no pointer, count or RAM activity, no error.
REQ-030 enable=0: no new grants; read already in flight still completes with its data_valid pulse.
REQ-031 full/empty derived from registered count; a grant affects them from the next cycle.

Reset
REQ-032 reset=1 at a rising edge: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, data_out=0, data_valid=0, prio=write.
REQ-033 Read in flight at reset is discarded; no data_valid pulse follows.
REQ-034 While reset=1, no grants: both acks 0, ram_en=0.

Verification
REQ-035 Reset -> empty=1, full=0, count=0, data_out=0x00, data_valid=0.
REQ-036 enable=1, write held 10 cycles with data 0x01..0x0A -> 10 write_acks, ram_addr 0..9, count=10; then read held -> data_out 0x01..0x0A in order, each data_valid 2 cycles after its read_ack.
REQ-037 count=5, read and write held together 6 cycles -> grants W,R,W,R,W,R; count alternates 6,5; read data matches FIFO order.
REQ-038 16384 writes -> full=1, count=16384, 16385th write gets write_ack=0; one read then one write -> write lands at ram_addr 0 (wrap), full=1 again.
REQ-039 Empty, read held 5 cycles -> read_ack=0, ram_en=0, no data_valid.
REQ-040 Read granted in cycle N, reset=1 in cycle N+1 -> no data_valid in N+2, count=0, empty=1.
